quad_step_decoder: RTL and testbench

- Upstream stage for the up/down/load counter.
- Converts asynchronous quadrature encoder inputs (A, B) and an index pulse into single-cycle registered up, down and load strobes, plus a preset data word.
- Outputs connect directly to the counter's up, down, load and data inputs on the same clk.
- Detects illegal quadrature transitions and holds a sticky error flag.

---
 rtl/qsd_pkg.sv | 45 ++++
 rtl/qsd_sync.sv | 65 ++++++
 rtl/quad_step_decoder.sv | 91 +++++++++
 tb/tb_quad_step_decoder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/qsd_pkg.sv
// Shared types and the quadrature step decode for quad_step_decoder.
// Gray-code phase order is 00 -> 01 -> 11 -> 10 -> 00 for forward motion.
package qsd_pkg;

  typedef enum logic [1:0] {
    PH00 = 2'b00,
    PH01 = 2'b01,
    PH11 = 2'b11,
    PH10 = 2'b10
  } phase_t;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DN   = 2'd2,
    STEP_ERR  = 2'd3
  } step_t;

  function automatic phase_t phase_fwd(input phase_t p);
    phase_t n;
    case (p)
      PH00:    n = PH01;
      PH01:    n = PH11;
      PH11:    n = PH10;
      default: n = PH00;
    endcase
    return n;
  endfunction

  // A change to the forward neighbour is an up step, to the backward
  // neighbour a down step; the only remaining change is a double transition.
  function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
    phase_t p;
    phase_t c;
    step_t  s;
    p = phase_t'(prev);
    c = phase_t'(cur);
    if (c == p)                s = STEP_NONE;
    else if (c == phase_fwd(p)) s = STEP_UP;
    else if (p == phase_fwd(c)) s = STEP_DN;
    else                        s = STEP_ERR;
    return s;
  endfunction

endpackage

// File: rtl/qsd_sync.sv
// Two-flop synchronizer for one asynchronous encoder pin. With
// QSD_GLITCH_FILTER_EN defined, a stability filter of FILT_CYC samples follows.
module qsd_sync #(
  parameter int FILT_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

`ifdef QSD_GLITCH_FILTER_EN
  localparam int CW = (FILT_CYC > 2) ? $clog2(FILT_CYC) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          filt_q;
  logic          filt_d;

  // cnt_q counts consecutive samples that disagree with the accepted level;
  // the FILT_CYC-th disagreeing sample flips the level.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (s2_q != filt_q) begin
      if (cnt_q == CW'(FILT_CYC - 1)) begin
        filt_d = s2_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign q_o = filt_q;
`else
  localparam int unused_filt_cyc = FILT_CYC;

  assign q_o = s2_q;
`endif

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature/index front end producing registered up/down/load strobes for a
// counter. Optional glitch filter: define QSD_GLITCH_FILTER_EN.
module quad_step_decoder
  import qsd_pkg::*;
#(
  parameter int W        = 8,
  parameter int FILT_CYC = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_in,
  input  logic         b_in,
  input  logic         idx_in,
  input  logic         en,
  input  logic         idx_en,
  input  logic [W-1:0] preset_val,
  input  logic         err_clr,
  output logic         up,
  output logic         down,
  output logic         load,
  output logic [W-1:0] data,
  output logic         err
);

  logic a_s;
  logic b_s;
  logic i_s;

  qsd_sync #(.FILT_CYC(FILT_CYC)) u_sync_a (.clk(clk), .rst(rst), .d_i(a_in),   .q_o(a_s));
  qsd_sync #(.FILT_CYC(FILT_CYC)) u_sync_b (.clk(clk), .rst(rst), .d_i(b_in),   .q_o(b_s));
  qsd_sync #(.FILT_CYC(FILT_CYC)) u_sync_i (.clk(clk), .rst(rst), .d_i(idx_in), .q_o(i_s));

  logic [1:0]   prev_ab_q, prev_ab_d;
  logic         idx_prev_q, idx_prev_d;
  logic         primed_q, primed_d;
  logic         up_q, up_d;
  logic         down_q, down_d;
  logic         load_q, load_d;
  logic [W-1:0] data_q, data_d;
  logic         err_q, err_d;
  step_t        step;

  // prev_ab and idx_prev track every cycle regardless of en, so re-enabling
  // never yields a stale step. The first edge after reset only captures levels.
  always_comb begin
    step       = decode_step(prev_ab_q, {a_s, b_s});
    prev_ab_d  = {a_s, b_s};
    idx_prev_d = i_s;
    primed_d   = 1'b1;
    load_d     = primed_q && idx_en && i_s && !idx_prev_q;
    up_d       = primed_q && en && !load_d && (step == STEP_UP);
    down_d     = primed_q && en && !load_d && (step == STEP_DN);
    data_d     = load_d ? preset_val : data_q;
    err_d      = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (primed_q && (step == STEP_ERR)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_ab_q  <= 2'b00;
      idx_prev_q <= 1'b0;
      primed_q   <= 1'b0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      load_q     <= 1'b0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      prev_ab_q  <= prev_ab_d;
      idx_prev_q <= idx_prev_d;
      primed_q   <= primed_d;
      up_q       <= up_d;
      down_q     <= down_d;
      load_q     <= load_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  assign up   = up_q;
  assign down = down_q;
  assign load = load_q;
  assign data = data_q;
  assign err  = err_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Self-checking bench for quad_step_decoder: table of held input patterns with
// expected strobe counts, latency and err level, plus reset and glitch sequences.
module tb_quad_step_decoder;

`ifdef QSD_GLITCH_FILTER_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif
  localparam int H = LAT + 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_in, b_in, idx_in, en, idx_en, err_clr;
  logic [7:0] preset_val;
  logic       up, down, load, err;
  logic [7:0] data;

  quad_step_decoder #(.W(8), .FILT_CYC(4)) dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .idx_in(idx_in),
    .en(en), .idx_en(idx_en), .preset_val(preset_val), .err_clr(err_clr),
    .up(up), .down(down), .load(load), .data(data), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       a, b, idx, en, idx_en, clr;
    logic [7:0] preset;
    int         hold;
    int         e_up, e_dn, e_ld;
    logic [7:0] e_data;
    int         e_err;  // -1: not checked
    int         e_lat;  // 0: not checked
  } vec_t;

  typedef struct {
    int         up, dn, ld;
    logic [7:0] data;
    int         err;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_no = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (vector %0d): got %0d, expected %0d", name, vec_no, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic a, input logic b, input logic idx,
                              input logic e, input logic ie, input logic clr,
                              input logic [7:0] pre, input int hold,
                              input int eu, input int ed, input int el,
                              input logic [7:0] edat, input int eerr, input int elat);
    vec_t v;
    v.a = a; v.b = b; v.idx = idx; v.en = e; v.idx_en = ie; v.clr = clr;
    v.preset = pre; v.hold = hold;
    v.e_up = eu; v.e_dn = ed; v.e_ld = el; v.e_data = edat;
    v.e_err = eerr; v.e_lat = elat;
    return v;
  endfunction

  // Called at a falling edge; drives the pattern, observes hold falling edges.
  task automatic apply(input vec_t v);
    exp_t e;
    int   n_up, n_dn, n_ld, first;
    a_in = v.a; b_in = v.b; idx_in = v.idx; en = v.en; idx_en = v.idx_en;
    err_clr = v.clr; preset_val = v.preset;
    e.up = v.e_up; e.dn = v.e_dn; e.ld = v.e_ld; e.data = v.e_data;
    e.err = v.e_err; e.lat = v.e_lat;
    exp_q.push_back(e);
    n_up = 0; n_dn = 0; n_ld = 0; first = 0;
    for (int i = 1; i <= v.hold; i++) begin
      @(negedge clk);
      if (up)   n_up++;
      if (down) n_dn++;
      if (load) n_ld++;
      if ((up || down || load) && first == 0) first = i;
      chk("strobes_exclusive", int'(up) + int'(down) + int'(load) > 1 ? 1 : 0, 0);
      if (load) chk("data_on_load", int'(data), int'(v.e_data));
    end
    e = exp_q.pop_front();
    chk("up_count", n_up, e.up);
    chk("down_count", n_dn, e.dn);
    chk("load_count", n_ld, e.ld);
    if (e.err >= 0) chk("err_level", int'(err), e.err);
    if (e.lat > 0)  chk("strobe_latency", first, e.lat);
    vec_no++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; a_in = 0; b_in = 0; idx_in = 0; en = 1; idx_en = 0;
    err_clr = 0; preset_val = 8'h00;

    // a, b, idx, en, idx_en, clr, preset, hold, up, dn, ld, data, err, lat
    tbl.push_back(mk(0,0,0,1,0,0,8'h00,H+2,   0,0,0,8'h00,0,0));   // settle at 00
    tbl.push_back(mk(0,1,0,1,0,0,8'h00,H,     1,0,0,8'h00,0,LAT)); // forward steps
    tbl.push_back(mk(1,1,0,1,0,0,8'h00,H,     1,0,0,8'h00,0,LAT));
    tbl.push_back(mk(1,0,0,1,0,0,8'h00,H,     1,0,0,8'h00,0,LAT));
    tbl.push_back(mk(0,0,0,1,0,0,8'h00,H,     1,0,0,8'h00,0,LAT));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,H,     0,0,0,8'h00,0,0));   // reverse, disabled
    tbl.push_back(mk(1,1,0,0,0,0,8'h00,H,     0,0,0,8'h00,0,0));
    tbl.push_back(mk(1,1,0,1,0,0,8'h00,4,     0,0,0,8'h00,0,0));   // enable, no step
    tbl.push_back(mk(0,1,0,1,0,0,8'h00,H,     0,1,0,8'h00,0,LAT));
    tbl.push_back(mk(0,0,0,1,0,0,8'h00,H,     0,1,0,8'h00,0,LAT));
    tbl.push_back(mk(0,1,0,1,0,0,8'h00,H,     1,0,0,8'h00,0,LAT));
    tbl.push_back(mk(1,0,0,1,0,0,8'h00,20+LAT,0,0,0,8'h00,1,0));   // 01->10 illegal
    tbl.push_back(mk(1,0,0,1,0,1,8'h00,1,     0,0,0,8'h00,0,0));   // clear
    tbl.push_back(mk(1,0,0,1,0,0,8'h00,4,     0,0,0,8'h00,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,8'h00,H,     1,0,0,8'h00,0,LAT));
    tbl.push_back(mk(1,1,0,1,0,0,8'h00,LAT-1, 0,0,0,8'h00,0,0));   // 00->11 illegal
    tbl.push_back(mk(1,1,0,1,0,1,8'h00,1,     0,0,0,8'h00,1,0));   // set beats clear
    tbl.push_back(mk(1,1,0,1,0,0,8'h00,4,     0,0,0,8'h00,1,0));
    tbl.push_back(mk(1,1,0,1,0,1,8'h00,1,     0,0,0,8'h00,0,0));
    tbl.push_back(mk(1,1,0,1,0,0,8'h00,4,     0,0,0,8'h00,0,0));
    tbl.push_back(mk(1,1,1,1,1,0,8'hA5,H,     0,0,1,8'hA5,0,LAT)); // index load
    tbl.push_back(mk(1,1,0,1,1,0,8'hA5,H,     0,0,0,8'hA5,0,0));
    tbl.push_back(mk(1,1,1,1,0,0,8'h5A,H,     0,0,0,8'h5A,0,0));   // idx_en=0
    tbl.push_back(mk(1,1,0,1,1,0,8'h5A,H,     0,0,0,8'h5A,0,0));
    tbl.push_back(mk(1,0,1,1,1,0,8'h3C,H,     0,0,1,8'h3C,0,LAT)); // load beats step
    tbl.push_back(mk(1,0,0,1,1,0,8'h3C,H,     0,0,0,8'h3C,0,0));
    tbl.push_back(mk(0,0,0,1,1,0,8'h3C,H,     1,0,0,8'h3C,0,LAT));

    repeat (3) begin
      @(negedge clk);
      chk("reset_up", int'(up), 0);
      chk("reset_down", int'(down), 0);
      chk("reset_load", int'(load), 0);
      chk("reset_data", int'(data), 0);
      chk("reset_err", int'(err), 0);
    end
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Reset in the middle of a step; data held 8'h3C before this.
    a_in = 0; b_in = 1;
    @(negedge clk);
    a_in = 1; b_in = 1; rst = 1'b1;
    #1;
    chk("async_rst_data", int'(data), 0);
    chk("async_rst_err", int'(err), 0);
    repeat (3) begin
      @(negedge clk);
      chk("in_rst_strobes", int'(up) + int'(down) + int'(load), 0);
    end
    rst = 1'b0;
    apply(mk(1,1,0,1,0,0,8'h00,LAT+6,0,0,0,8'h00,-1,0)); // priming: no strobe
    apply(mk(1,1,0,1,0,1,8'h00,1,    0,0,0,8'h00,0,0));
    apply(mk(1,1,0,1,0,0,8'h00,4,    0,0,0,8'h00,0,0));
    apply(mk(1,0,0,1,0,0,8'h00,H,    1,0,0,8'h00,0,LAT));

`ifdef QSD_GLITCH_FILTER_EN
    apply(mk(0,0,0,1,0,0,8'h00,2,    0,0,0,8'h00,0,0));   // 2-cycle A glitch
    apply(mk(1,0,0,1,0,0,8'h00,12,   0,0,0,8'h00,0,0));
    apply(mk(0,0,0,1,0,0,8'h00,10,   1,0,0,8'h00,0,LAT));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
